// File: rtl/req_encoder.sv
// ---------------------------------------------------------------------------
// req_encoder
//
// Sequential N-to-log2(N) request encoder. Request bits are accumulated into
// a pending register, and one binary index per transfer is issued on a
// valid/ready output port. Each bit is cleared as it is issued.
//
// Parameters:
//   N  number of request lines (power of two, 2..16)
//   W  width of the encoded index, derived as $clog2(N)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   req_in      request bits, sampled every cycle (several may be set)
//   code_out    encoded index of the issued request
//   code_valid  code_out holds an unconsumed index
//   code_ready  consumer accepts code_out this cycle when code_valid=1
//   pending     requests captured but not yet issued
//   busy        |pending OR code_valid
//
// Configuration macro:
//   REQ_ENC_ROUND_ROBIN_EN  when defined, the search starts one past the
//                           last issued index and wraps (round robin).
//                           When undefined, the lowest set index always
//                           wins and no grant pointer is built.
// ---------------------------------------------------------------------------
module req_encoder #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    output logic [W-1:0] code_out,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [N-1:0] pending,
    output logic         busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         load;
    logic [W-1:0] sel_idx;
    logic [W-1:0] start_idx;
    logic [N-1:0] clear_mask;

`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [W-1:0] grant_ptr;

    // The pointer holds the last issued index, so the search begins one past
    // it. N is a power of two, so the W-bit add wraps modulo N for free.
    assign start_idx = grant_ptr + W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_ptr <= W'(N - 1);
        end else if (load) begin
            grant_ptr <= sel_idx;
        end
    end
`else
    assign start_idx = '0;
`endif

    // Walk the offsets from highest to lowest so that the last assignment,
    // which is the smallest offset from start_idx, wins. Only the registered
    // pending vector is searched; req_in of this cycle is not yet eligible.
    always_comb begin
        sel_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[start_idx + W'(i)]) begin
                sel_idx = start_idx + W'(i);
            end
        end
    end

    // Next-state logic: a new index is loaded whenever the output slot is
    // empty or is being consumed this cycle, provided something is pending.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            EMPTY: begin
                if (|pending) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (code_ready) begin
                    if (|pending) begin
                        load = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Bit to clear from pending on the edge that loads code_out.
    always_comb begin
        clear_mask = '0;
        if (load) begin
            clear_mask = N'(1) << sel_idx;
        end
    end

    // State, pending and code registers. OR-ing req_in after the clear makes
    // a bit that is issued and re-requested on the same edge stay pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            pending  <= '0;
            code_out <= '0;
        end else begin
            state   <= state_next;
            pending <= (pending & ~clear_mask) | req_in;
            if (load) begin
                code_out <= sel_idx;
            end
        end
    end

    // Outputs are decoded from registers only.
    always_comb begin
        code_valid = (state == FULL);
        busy       = (|pending) | (state == FULL);
    end

endmodule

// File: tb/tb_req_encoder.sv
// ---------------------------------------------------------------------------
// tb_req_encoder
//
// Self-checking bench for req_encoder (N=4). Holds a table of directed
// vectors with constant expectations, a few hand-written multi-cycle
// sequences, and a randomized phase compared against a behavioural model
// built from a request set and a single output slot.
// ---------------------------------------------------------------------------
module tb_req_encoder;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_in;
    logic [W-1:0] code_out;
    logic         code_valid;
    logic         code_ready;
    logic [N-1:0] pending;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    req_encoder #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: a set of outstanding requests plus one output slot.
    bit m_pend [N];
    bit m_valid;
    int m_code;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    int m_last;
`endif

    task automatic modelReset();
        for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
        m_valid = 1'b0;
        m_code  = 0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
        m_last  = N - 1;
`endif
    endtask

    // One clock edge of the model: if the slot is free (empty or consumed),
    // take the highest-priority outstanding request out of the set; then
    // add this cycle's requests to the set.
    task automatic modelStep(input logic [N-1:0] r, input logic rdy);
        int pick;
        pick = -1;
        if (!m_valid || rdy) begin
            for (int k = 0; k < N; k++) begin
                int idx;
`ifdef REQ_ENC_ROUND_ROBIN_EN
                idx = (m_last + 1 + k) % N;
`else
                idx = k;
`endif
                if (pick < 0 && m_pend[idx]) pick = idx;
            end
            if (pick >= 0) begin
                m_valid      = 1'b1;
                m_code       = pick;
                m_pend[pick] = 1'b0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
                m_last       = pick;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (r[k]) m_pend[k] = 1'b1;
        end
    endtask

    function automatic logic [N-1:0] modelPending();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_pend[k];
        return v;
    endfunction

    // Drive inputs, advance the model and the DUT one edge, sample at +1.
    task automatic applyStimulus(input logic [N-1:0] r, input logic rdy);
        req_in     = r;
        code_ready = rdy;
        modelStep(r, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_valid,
                               input logic [W-1:0] exp_code,
                               input logic [N-1:0] exp_pend);
        logic exp_busy;
        exp_busy = (|exp_pend) | exp_valid;
        checks++;
        if (code_valid !== exp_valid || (exp_valid && code_out !== exp_code) ||
            pending !== exp_pend || busy !== exp_busy) begin
            failures++;
            $display("[TB] FAIL %s: got valid=%b code=%0d pending=%b busy=%b, expected valid=%b code=%0d pending=%b busy=%b",
                     name, code_valid, code_out, pending, busy,
                     exp_valid, exp_code, exp_pend, exp_busy);
        end
    endtask

    task automatic resetDut();
        rst        = 1'b1;
        req_in     = '0;
        code_ready = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic         exp_valid;
        logic [W-1:0] exp_code;
        logic [N-1:0] exp_pend;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Multiple requests, lowest index first: 0,1,3 then empty.
        vecs.push_back('{4'b1011, 1'b1, 1'b0, 2'd0, 4'b1011});
        vecs.push_back('{4'b0000, 1'b1, 1'b1, 2'd0, 4'b1010});
        vecs.push_back('{4'b0000, 1'b1, 1'b1, 2'd1, 4'b1000});
        vecs.push_back('{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});
        // Single request: code 2 two edges after it is presented.
        vecs.push_back('{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100});
        vecs.push_back('{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});
        // Backpressure: code 1 held for five stalled cycles, then 2.
        vecs.push_back('{4'b0110, 1'b0, 1'b0, 2'd0, 4'b0110});
        vecs.push_back('{4'b0000, 1'b0, 1'b1, 2'd1, 4'b0100});
        for (int k = 0; k < 5; k++)
            vecs.push_back('{4'b0000, 1'b0, 1'b1, 2'd1, 4'b0100});
        vecs.push_back('{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});

        // Reset state.
        resetDut();
        checkOutput("reset_state", 1'b0, 2'd0, 4'b0000);
        checks++;
        if (code_out !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_code: got %0d expected 0", code_out);
        end

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid,
                        vecs[i].exp_code, vecs[i].exp_pend);
        end

        // Set wins: index 0 issued from FULL while req_in[0] is high.
        resetDut();
        applyStimulus(4'b0011, 1'b0);
        checkOutput("setwin_capture", 1'b0, 2'd0, 4'b0011);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("setwin_load0", 1'b1, 2'd0, 4'b0010);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("setwin_issue1", 1'b1, 2'd1, 4'b0001);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("setwin_collide", 1'b1, 2'd0, 4'b0001);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("setwin_reissue", 1'b1, 2'd0, 4'b0000);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("setwin_empty", 1'b0, 2'd0, 4'b0000);

        // Asynchronous reset in FULL with pending=1010.
        resetDut();
        applyStimulus(4'b1011, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("prereset_full", 1'b1, 2'd0, 4'b1010);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (code_valid !== 1'b0 || code_out !== 2'd0 || pending !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got valid=%b code=%0d pending=%b busy=%b, expected all zero",
                     code_valid, code_out, pending, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();

        // Requests held high on every line with the consumer always ready.
        applyStimulus(4'b1111, 1'b1);
        checkOutput("hold_capture", 1'b0, 2'd0, 4'b1111);
        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] exp;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            exp = W'(k % N);
`else
            exp = '0;
`endif
            applyStimulus(4'b1111, 1'b1);
            checkOutput($sformatf("hold%0d", k), 1'b1, exp, 4'b1111);
        end

        // Randomized traffic against the model.
        resetDut();
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            logic         rdy;
            r   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(r, rdy);
            checkOutput($sformatf("rand%0d", k), m_valid, W'(m_code), modelPending());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
